// File: rtl/dual_frame_buffer_if.sv
// Bus bundle for dual_frame_buffer: renderer write port, swap control and display read port.
// The master modport is the renderer/timing side; the slave modport is the frame buffer itself.
interface dual_frame_buffer_if #(
    parameter int PIX_W = 16,
    parameter int AW    = 16,
    parameter int HW    = 11,
    parameter int VW    = 10
);
    logic [PIX_W-1:0] wr_data_in;
    logic [AW-1:0]    wr_addr_in;
    logic             wr_en_in;
    logic             wr_ready_out;
    logic             wr_err_out;
    logic             swap_req_in;
    logic             swap_pending_out;
    logic             swap_done_out;
    logic             front_sel_out;
    logic             rd_en_in;
    logic [HW-1:0]    hcount_in;
    logic [VW-1:0]    vcount_in;
    logic [PIX_W-1:0] pix_out;
    logic             pix_valid_out;

    modport master (
        output wr_data_in, wr_addr_in, wr_en_in, swap_req_in, rd_en_in, hcount_in, vcount_in,
        input  wr_ready_out, wr_err_out, swap_pending_out, swap_done_out, front_sel_out,
               pix_out, pix_valid_out
    );

    modport slave (
        input  wr_data_in, wr_addr_in, wr_en_in, swap_req_in, rd_en_in, hcount_in, vcount_in,
        output wr_ready_out, wr_err_out, swap_pending_out, swap_done_out, front_sel_out,
               pix_out, pix_valid_out
    );
endinterface

// File: rtl/dual_frame_buffer.sv
// Double-buffered frame buffer with tear-free swap at the frame boundary and 2-cycle upscaled reads.
// Optional FB_CLEAR_ON_SWAP_EN: sweep the new back buffer with CLEAR_COLOR after every swap.
//
// state   | meaning
// IDLE    | no swap requested
// PENDING | swap latched, waiting for hcount==0 && vcount==0
// CLEAR   | sweeping new back buffer, writes blocked (FB_CLEAR_ON_SWAP_EN only)
module dual_frame_buffer #(
    parameter int               PIX_W        = 16,
    parameter int               FB_WIDTH     = 320,
    parameter int               FB_HEIGHT    = 180,
    parameter int               DISP_WIDTH   = 1280,
    parameter int               DISP_HEIGHT  = 720,
    parameter int               SCALE_SHIFT  = 2,
    parameter logic [PIX_W-1:0] BORDER_COLOR = '0,
    parameter logic [PIX_W-1:0] CLEAR_COLOR  = '0
) (
    input logic               clk_in,
    input logic               rst_n_in,
    dual_frame_buffer_if.slave bus
);
    localparam int          N     = FB_WIDTH * FB_HEIGHT;
    localparam int          AW    = $clog2(N);
    localparam int          HW    = $clog2(DISP_WIDTH);
    localparam int          VW    = $clog2(DISP_HEIGHT);
    localparam logic [31:0] FBW_V = 32'(FB_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1
`ifdef FB_CLEAR_ON_SWAP_EN
        ,
        CLEAR   = 2'd2
`endif
    } state_t;

    // Constant multiply unrolled into shift-adds so no DSP is inferred.
    function automatic logic [AW-1:0] lin_addr(input logic [HW-1:0] x, input logic [VW-1:0] y);
        logic [31:0] acc;
        acc = 32'(x);
        for (int k = 0; k < 32; k++) begin
            if (FBW_V[k]) acc = acc + (32'(y) << k);
        end
        return acc[AW-1:0];
    endfunction

    state_t           state_q, state_d;
    logic             front_sel_q, front_sel_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rdy_q;
    logic             boundary;
    logic             wr_ready;
    logic             wr_in_range;
    logic             wr_fire;
    logic             clr_active;
    logic [AW-1:0]    clr_addr;

    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [PIX_W-1:0] ram_wdata;
    logic [PIX_W-1:0] mem0 [N];
    logic [PIX_W-1:0] mem1 [N];
    logic [PIX_W-1:0] rd0_q, rd1_q;
    logic [AW-1:0]    rd_addr;

    logic [HW-1:0]    bx_c, bx_q;
    logic [VW-1:0]    by_c, by_q;
    logic             inr_c, inr0_q, inr1_q;
    logic             vld0_q, vld1_q;
    logic             sel0_q, sel1_q;
    logic [PIX_W-1:0] pix_sel;

    assign boundary    = (bus.hcount_in == '0) && (bus.vcount_in == '0);
    assign wr_ready    = rdy_q && !clr_active;
    assign wr_in_range = 32'(bus.wr_addr_in) < N;
    assign wr_fire     = bus.wr_en_in && wr_ready && wr_in_range;

`ifdef FB_CLEAR_ON_SWAP_EN
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          latch_q, latch_d;
    logic          clr_last;

    assign clr_active = (state_q == CLEAR);
    assign clr_addr   = clr_cnt_q;
    assign clr_last   = (clr_cnt_q == AW'(N - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            clr_cnt_q <= '0;
            latch_q   <= 1'b0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
            latch_q   <= latch_d;
        end
    end
`else
    assign clr_active = 1'b0;
    assign clr_addr   = '0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            front_sel_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            front_sel_q <= front_sel_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdy_q       <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        front_sel_d = front_sel_q;
        done_d      = 1'b0;
        err_d       = err_q | (bus.wr_en_in && wr_ready && !wr_in_range);
`ifdef FB_CLEAR_ON_SWAP_EN
        clr_cnt_d   = clr_cnt_q;
        latch_d     = latch_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.swap_req_in) state_d = PENDING;
            end
            PENDING: begin
                // Further requests here are merged into the one already latched.
                if (boundary) begin
                    front_sel_d = ~front_sel_q;
                    done_d      = 1'b1;
`ifdef FB_CLEAR_ON_SWAP_EN
                    state_d     = CLEAR;
                    clr_cnt_d   = '0;
                    latch_d     = 1'b0;
`else
                    state_d     = IDLE;
`endif
                end
            end
`ifdef FB_CLEAR_ON_SWAP_EN
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (bus.swap_req_in) latch_d = 1'b1;
                if (clr_last) begin
                    state_d   = (latch_q || bus.swap_req_in) ? PENDING : IDLE;
                    latch_d   = 1'b0;
                    clr_cnt_d = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Writes land in the buffer that is not front as of this edge, so a write on the
    // swap edge still goes to the pre-swap back buffer.
    assign ram_we    = wr_fire || clr_active;
    assign ram_waddr = clr_active ? clr_addr : bus.wr_addr_in;
    assign ram_wdata = clr_active ? CLEAR_COLOR : bus.wr_data_in;

    always_ff @(posedge clk_in) begin
        if (ram_we && front_sel_q)  mem0[ram_waddr] <= ram_wdata;
        if (ram_we && !front_sel_q) mem1[ram_waddr] <= ram_wdata;
        rd0_q <= mem0[rd_addr];
        rd1_q <= mem1[rd_addr];
    end

    assign bx_c  = bus.hcount_in >> SCALE_SHIFT;
    assign by_c  = bus.vcount_in >> SCALE_SHIFT;
    assign inr_c = (32'(bx_c) < FB_WIDTH) && (32'(by_c) < FB_HEIGHT);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bx_q   <= '0;
            by_q   <= '0;
            inr0_q <= 1'b0;
            vld0_q <= 1'b0;
            sel0_q <= 1'b0;
            inr1_q <= 1'b0;
            vld1_q <= 1'b0;
            sel1_q <= 1'b0;
        end else begin
            bx_q   <= bx_c;
            by_q   <= by_c;
            inr0_q <= inr_c;
            vld0_q <= bus.rd_en_in;
            sel0_q <= front_sel_q;
            inr1_q <= inr0_q;
            vld1_q <= vld0_q;
            sel1_q <= sel0_q;
        end
    end

    // Out-of-range coordinates read address 0; the data is discarded in favour of the border.
    assign rd_addr = inr0_q ? lin_addr(bx_q, by_q) : '0;
    assign pix_sel = sel1_q ? rd1_q : rd0_q;

    assign bus.pix_out          = vld1_q ? (inr1_q ? pix_sel : BORDER_COLOR) : '0;
    assign bus.pix_valid_out    = vld1_q;
    assign bus.wr_ready_out     = wr_ready;
    assign bus.wr_err_out       = err_q;
    assign bus.swap_done_out    = done_q;
    assign bus.front_sel_out    = front_sel_q;
`ifdef FB_CLEAR_ON_SWAP_EN
    assign bus.swap_pending_out = (state_q == PENDING) || latch_q;
`else
    assign bus.swap_pending_out = (state_q == PENDING);
`endif
endmodule
